// File: rtl/stopwatch_ctrl_if.sv
// Front-panel bundle: raw buttons toward the controller and counter controls back out.
interface stopwatch_ctrl_if;
   logic       btn_start;
   logic       btn_pause;
   logic       btn_clear;
   logic       start;
   logic       pause;
   logic       clr_n;
   logic [1:0] state;

   modport master (
      output btn_start, btn_pause, btn_clear,
      input  start, pause, clr_n, state
   );

   modport slave (
      input  btn_start, btn_pause, btn_clear,
      output start, pause, clr_n, state
   );
endinterface

// File: rtl/stopwatch_ctrl.sv
// Stopwatch front panel: per-button sync/debounce/press-edge lanes feeding a
// 3-state start/pause FSM with a one-cycle counter clear strobe.
module stopwatch_btn #(
   parameter int unsigned DEBOUNCE_CYCLES = 500_000,
   parameter int unsigned SYNC_STAGES     = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic raw,
   output logic press
);
   localparam logic [31:0] CNT_LAST = 32'(DEBOUNCE_CYCLES - 1);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   synced;
   logic [31:0]            cnt;
   logic                   db;
   logic                   db_d;

   assign synced = sync_q[SYNC_STAGES-1];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) sync_q <= '0;
      else      sync_q <= {sync_q[SYNC_STAGES-2:0], raw};
   end

   // Any return to the accepted level restarts the count, rejecting short glitches.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt <= '0;
         db  <= 1'b0;
      end else if (synced == db) begin
         cnt <= '0;
      end else if (cnt == CNT_LAST) begin
         db  <= synced;
         cnt <= '0;
      end else begin
         cnt <= cnt + 32'd1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         db_d  <= 1'b0;
         press <= 1'b0;
      end else begin
         db_d  <= db;
         press <= db & ~db_d;
      end
   end
endmodule

module stopwatch_ctrl #(
   parameter int unsigned DEBOUNCE_CYCLES = 500_000,
   parameter int unsigned SYNC_STAGES     = 2
) (
   input  logic            clk,
   input  logic            rst,
   stopwatch_ctrl_if.slave bus
);
   localparam int NUM_BTN = 3;
   localparam int B_START = 0;
   localparam int B_PAUSE = 1;
   localparam int B_CLEAR = 2;

   typedef enum logic [1:0] {
      S_IDLE   = 2'b00,
      S_RUN    = 2'b01,
      S_PAUSED = 2'b10
   } state_t;

   logic [NUM_BTN-1:0] btn_raw;
   logic [NUM_BTN-1:0] press;
   state_t             state_q, state_d;
   logic               start_q, pause_q, clr_n_q;
   logic               start_d, pause_d, clr_n_d;

   assign btn_raw = {bus.btn_clear, bus.btn_pause, bus.btn_start};

   stopwatch_btn #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .SYNC_STAGES     (SYNC_STAGES)
   ) u_btn [NUM_BTN-1:0] (
      .clk   (clk),
      .rst   (rst),
      .raw   (btn_raw),
      .press (press)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= S_IDLE;
         start_q <= 1'b0;
         pause_q <= 1'b0;
         clr_n_q <= 1'b1;
      end else begin
         state_q <= state_d;
         start_q <= start_d;
         pause_q <= pause_d;
         clr_n_q <= clr_n_d;
      end
   end

   // Only the highest-priority press of a cycle is acted on; the rest are dropped.
   always_comb begin
      state_d = state_q;
      if (press[B_CLEAR]) begin
         state_d = S_IDLE;
      end else if (press[B_START]) begin
         case (state_q)
            S_IDLE:  state_d = S_RUN;
            S_RUN:   state_d = S_IDLE;
            default: state_d = state_q;
         endcase
      end else if (press[B_PAUSE]) begin
         case (state_q)
            S_RUN:    state_d = S_PAUSED;
            S_PAUSED: state_d = S_RUN;
            default:  state_d = state_q;
         endcase
      end
   end

   // Decoded from the next state so start/pause/clr_n land on the same edge as state.
   always_comb begin
      start_d = (state_d != S_IDLE);
      pause_d = (state_d == S_PAUSED);
      clr_n_d = ~press[B_CLEAR];
   end

   assign bus.start = start_q;
   assign bus.pause = pause_q;
   assign bus.clr_n = clr_n_q;
   assign bus.state = state_q;
endmodule
